// File: rtl/serial_pkg.sv
// Types and constants shared by the serializer and the sequence detector that consumes its stream.
package serial_pkg;

  typedef enum logic [0:0] {
    S_IDLE,
    S_SHIFT
  } state_e;

  // Level held on x between frames; the detector bench relies on the same value.
  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: takes words over valid/ready and shifts each one out as a
// contiguous frame on x, back-to-back when the next word is already waiting.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             last_bit;
  logic             xfer;
  logic [WIDTH-1:0] shreg_next;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // The bit currently on x is always the head of shreg_q; cnt_q is its index in the frame.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    x_d           = IDLE_BIT;
    frame_start_d = 1'b0;
    shreg_next    = shift_word(shreg_q);

    last_bit  = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
    din_ready = !rst && ((state_q == S_IDLE) || last_bit);
    xfer      = din_valid && din_ready;

    if (xfer) begin
      state_d       = S_SHIFT;
      cnt_d         = '0;
      shreg_d       = din;
      x_d           = head_bit(din);
      frame_start_d = 1'b1;
    end else if ((state_q == S_SHIFT) && !last_bit) begin
      cnt_d   = cnt_q + CNT_W'(1);
      shreg_d = shreg_next;
      x_d     = head_bit(shreg_next);
    end else begin
      state_d = S_IDLE;
      cnt_d   = '0;
      shreg_d = '0;
    end

    x_valid_d    = (state_d == S_SHIFT);
    busy_d       = (state_d == S_SHIFT);
    // Flag the final bit one cycle ahead so the pulse lands on it as a registered output.
    frame_done_d = (state_d == S_SHIFT) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      x_q           <= IDLE_BIT;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      x_q           <= x_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Drives an MSB-first and an LSB-first serializer in lockstep and checks both against a
// queue-of-pending-bits model, cycle by cycle.
module tb_bit_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         din_valid;
  logic [W-1:0] din;
  logic [1:0]   din_ready, x, x_valid, frame_start, frame_done, busy;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[0]),
    .x(x[0]), .x_valid(x_valid[0]), .frame_start(frame_start[0]),
    .frame_done(frame_done[0]), .busy(busy[0])
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[1]),
    .x(x[1]), .x_valid(x_valid[1]), .frame_start(frame_start[1]),
    .frame_done(frame_done[1]), .busy(busy[1])
  );

  // Per instance: bits still to appear on x, head = bit shown in the current cycle.
  bit          mq[2][$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input int k, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%b expected=%b t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  // One clock cycle with the given inputs held across the edge.
  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d);
    logic xfer[2];
    logic exp_rdy;
    int   sz;
    rst       = r;
    din_valid = v;
    din       = d;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_rdy = !r && (mq[k].size() <= 1);
      check("din_ready", k, din_ready[k], exp_rdy);
      xfer[k] = exp_rdy && v;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        mq[k].delete();
      end else begin
        if (mq[k].size() > 0) void'(mq[k].pop_front());
        if (xfer[k]) begin
          for (int i = 0; i < W; i++) mq[k].push_back((k == 0) ? d[W-1-i] : d[i]);
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      sz = mq[k].size();
      check("x", k, x[k], (sz > 0) ? mq[k][0] : 1'b0);
      check("x_valid", k, x_valid[k], sz > 0);
      check("busy", k, busy[k], sz > 0);
      check("frame_start", k, frame_start[k], xfer[k]);
      check("frame_done", k, frame_done[k], sz == 1);
    end
  endtask

  initial begin
    // Reset, then idle.
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    repeat (5) cyc(1'b0, 1'b0, '0);

    // Single frame, then back to idle.
    cyc(1'b0, 1'b1, 8'b1011_0010);
    repeat (10) cyc(1'b0, 1'b0, 8'hEE);

    // Back-to-back with din_valid held; the second word is taken on the last-bit cycle.
    cyc(1'b0, 1'b1, 8'hA5);
    repeat (8) cyc(1'b0, 1'b1, 8'h3C);
    repeat (10) cyc(1'b0, 1'b0, '0);

    // Single set bit exposes bit order on both instances.
    cyc(1'b0, 1'b1, 8'b0000_0001);
    repeat (9) cyc(1'b0, 1'b0, '0);

    // Reset after the third bit; the word offered alongside reset is dropped.
    cyc(1'b0, 1'b1, 8'hFF);
    repeat (2) cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 8'h55);
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 8'h81);
    repeat (9) cyc(1'b0, 1'b0, '0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), W'($urandom));
    end
    repeat (10) cyc(1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
